// File: rtl/id_queue_stage.sv
// Decode stage between fetch and execute: a DEPTH-entry FIFO of {pc, instr} pairs whose
// head is decoded into one-hot control vectors and held in a valid/ready output register.
module id_queue_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 4,
  parameter bit          EN_M  = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            F_valid_i,
  output logic            F_ready_o,
  input  logic [31:0]     F_instr_i,
  input  logic [XLEN-1:0] F_pc_i,
  input  logic            E_ready_i,
  output logic            D_valid_o,
  output logic [XLEN-1:0] D_pc_o,
  output logic [4:0]      D_rs1_o,
  output logic [4:0]      D_rs2_o,
  output logic [4:0]      D_dstE_o,
  output logic            D_need_dstE_o,
  output logic [10:0]     D_epcode_o,
  output logic [17:0]     D_ALU_op_o,
  output logic [5:0]      D_branch_op_o,
  output logic [3:0]      D_store_op_o,
  output logic [6:0]      D_load_op_o,
  output logic [XLEN-1:0] D_imme_o,
  output logic            D_sel_reg_o,
  output logic            D_word_o,
  output logic            D_illegal_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam bit          Rv64 = (XLEN == 64);

  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpAlur   = 7'b0110011;
  localparam logic [6:0] OpAlurw  = 7'b0111011;
  localparam logic [6:0] OpAlui   = 7'b0010011;
  localparam logic [6:0] OpAluiw  = 7'b0011011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      dst;
    logic            need_dst;
    logic [10:0]     epcode;
    logic [17:0]     alu_op;
    logic [5:0]      br_op;
    logic [3:0]      st_op;
    logic [6:0]      ld_op;
    logic [XLEN-1:0] imm;
    logic            sel_reg;
    logic            word;
    logic            illegal;
  } dec_t;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            out_valid_q;
  dec_t            out_q, dec;
  logic            push, pop;

  logic [31:0] head;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic        sh_ok, sh_ar_ok, legal;
  logic [31:0] imm32;

  assign F_ready_o = (count_q != CntW'(DEPTH));
  assign push      = F_valid_i & F_ready_o;
  assign pop       = (count_q != '0) & (~out_valid_q | E_ready_i);

  assign head = instr_mem[rd_ptr_q];
  assign opc  = head[6:0];
  assign f3   = head[14:12];
  assign f7   = head[31:25];
  // RV64 immediate shifts carry a 6-bit shamt, so bit 25 belongs to the shift amount.
  assign sh_ok    = Rv64 ? (head[31:26] == 6'b000000) : (f7 == 7'b0000000);
  assign sh_ar_ok = Rv64 ? (head[31:26] == 6'b010000) : (f7 == 7'b0100000);

  always_comb begin
    dec     = '0;
    dec.pc  = pc_mem[rd_ptr_q];
    dec.rs1 = head[19:15];
    dec.rs2 = head[24:20];
    dec.dst = head[11:7];
    imm32   = '0;
    legal   = 1'b1;
    case (opc)
      OpBranch: begin
        dec.epcode[0] = 1'b1;
        imm32 = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
        case (f3)
          3'b000:  dec.br_op[0] = 1'b1;
          3'b001:  dec.br_op[1] = 1'b1;
          3'b100:  dec.br_op[2] = 1'b1;
          3'b101:  dec.br_op[3] = 1'b1;
          3'b110:  dec.br_op[4] = 1'b1;
          3'b111:  dec.br_op[5] = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OpJal: begin
        dec.epcode[1] = 1'b1;
        imm32 = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
      end
      OpJalr: begin
        dec.epcode[2] = 1'b1;
        imm32 = {{20{head[31]}}, head[31:20]};
        legal = (f3 == 3'b000);
      end
      OpStore: begin
        dec.epcode[3] = 1'b1;
        imm32 = {{20{head[31]}}, head[31:25], head[11:7]};
        case (f3)
          3'b000:  dec.st_op[0] = 1'b1;
          3'b001:  dec.st_op[1] = 1'b1;
          3'b010:  dec.st_op[2] = 1'b1;
          3'b011:  begin dec.st_op[3] = 1'b1; legal = Rv64; end
          default: legal = 1'b0;
        endcase
      end
      OpLoad: begin
        dec.epcode[4] = 1'b1;
        imm32 = {{20{head[31]}}, head[31:20]};
        case (f3)
          3'b000:  dec.ld_op[0] = 1'b1;
          3'b001:  dec.ld_op[1] = 1'b1;
          3'b010:  dec.ld_op[2] = 1'b1;
          3'b011:  begin dec.ld_op[3] = 1'b1; legal = Rv64; end
          3'b100:  dec.ld_op[4] = 1'b1;
          3'b101:  dec.ld_op[5] = 1'b1;
          3'b110:  begin dec.ld_op[6] = 1'b1; legal = Rv64; end
          default: legal = 1'b0;
        endcase
      end
      OpAlur: begin
        dec.epcode[5] = 1'b1;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000:  dec.alu_op[0] = 1'b1;
              3'b001:  dec.alu_op[2] = 1'b1;
              3'b010:  dec.alu_op[3] = 1'b1;
              3'b011:  dec.alu_op[4] = 1'b1;
              3'b100:  dec.alu_op[5] = 1'b1;
              3'b101:  dec.alu_op[6] = 1'b1;
              3'b110:  dec.alu_op[8] = 1'b1;
              default: dec.alu_op[9] = 1'b1;
            endcase
          end
          7'b0100000: begin
            case (f3)
              3'b000:  dec.alu_op[1] = 1'b1;
              3'b101:  dec.alu_op[7] = 1'b1;
              default: legal = 1'b0;
            endcase
          end
          7'b0000001: begin
            legal = EN_M;
            case (f3)
              3'b000:  dec.alu_op[10] = 1'b1;
              3'b001:  dec.alu_op[11] = 1'b1;
              3'b010:  dec.alu_op[13] = 1'b1;
              3'b011:  dec.alu_op[12] = 1'b1;
              3'b100:  dec.alu_op[14] = 1'b1;
              3'b101:  dec.alu_op[15] = 1'b1;
              3'b110:  dec.alu_op[16] = 1'b1;
              default: dec.alu_op[17] = 1'b1;
            endcase
          end
          default: legal = 1'b0;
        endcase
      end
      OpAlurw: begin
        dec.epcode[6] = 1'b1;
        case ({f7, f3})
          {7'b0000000, 3'b000}: dec.alu_op[0] = 1'b1;
          {7'b0000000, 3'b001}: dec.alu_op[2] = 1'b1;
          {7'b0000000, 3'b101}: dec.alu_op[6] = 1'b1;
          {7'b0100000, 3'b000}: dec.alu_op[1] = 1'b1;
          {7'b0100000, 3'b101}: dec.alu_op[7] = 1'b1;
          default:              legal = 1'b0;
        endcase
        if (!Rv64) legal = 1'b0;
      end
      OpAlui: begin
        dec.epcode[7] = 1'b1;
        imm32 = {{20{head[31]}}, head[31:20]};
        case (f3)
          3'b000:  dec.alu_op[0] = 1'b1;
          3'b001:  begin dec.alu_op[2] = 1'b1; legal = sh_ok; end
          3'b010:  dec.alu_op[3] = 1'b1;
          3'b011:  dec.alu_op[4] = 1'b1;
          3'b100:  dec.alu_op[5] = 1'b1;
          3'b101: begin
            if (sh_ok)         dec.alu_op[6] = 1'b1;
            else if (sh_ar_ok) dec.alu_op[7] = 1'b1;
            else               legal = 1'b0;
          end
          3'b110:  dec.alu_op[8] = 1'b1;
          default: dec.alu_op[9] = 1'b1;
        endcase
      end
      OpAluiw: begin
        dec.epcode[8] = 1'b1;
        imm32 = {{20{head[31]}}, head[31:20]};
        case (f3)
          3'b000:  dec.alu_op[0] = 1'b1;
          3'b001:  begin dec.alu_op[2] = 1'b1; legal = (f7 == 7'b0000000); end
          3'b101: begin
            if (f7 == 7'b0000000)      dec.alu_op[6] = 1'b1;
            else if (f7 == 7'b0100000) dec.alu_op[7] = 1'b1;
            else                       legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
        if (!Rv64) legal = 1'b0;
      end
      OpLui: begin
        dec.epcode[9] = 1'b1;
        imm32 = {head[31:12], 12'b0};
      end
      OpAuipc: begin
        dec.epcode[10] = 1'b1;
        imm32 = {head[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase

    dec.need_dst = |{dec.epcode[10:4], dec.epcode[2:1]};
    dec.word     = dec.epcode[6] | dec.epcode[8];
    dec.sel_reg  = ~dec.epcode[4];
    dec.imm      = XLEN'($signed(imm32));
    dec.illegal  = ~legal;
    if (!legal) begin
      dec.epcode   = '0;
      dec.alu_op   = '0;
      dec.br_op    = '0;
      dec.st_op    = '0;
      dec.ld_op    = '0;
      dec.need_dst = 1'b0;
      dec.imm      = '0;
      dec.word     = 1'b0;
      dec.sel_reg  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush_i) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (pop) begin
        out_valid_q <= 1'b1;
        out_q       <= dec;
      end else if (E_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset; a flushed or reset cycle must not write.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i && !rst_i) begin
      pc_mem[wr_ptr_q]    <= F_pc_i;
      instr_mem[wr_ptr_q] <= F_instr_i;
    end
  end

  assign D_valid_o     = out_valid_q;
  assign D_pc_o        = out_q.pc;
  assign D_rs1_o       = out_q.rs1;
  assign D_rs2_o       = out_q.rs2;
  assign D_dstE_o      = out_q.dst;
  assign D_need_dstE_o = out_q.need_dst;
  assign D_epcode_o    = out_q.epcode;
  assign D_ALU_op_o    = out_q.alu_op;
  assign D_branch_op_o = out_q.br_op;
  assign D_store_op_o  = out_q.st_op;
  assign D_load_op_o   = out_q.ld_op;
  assign D_imme_o      = out_q.imm;
  assign D_sel_reg_o   = out_q.sel_reg;
  assign D_word_o      = out_q.word;
  assign D_illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_id_queue_stage.sv
// Bench for id_queue_stage: an RV64/M and an RV32/no-M instance share one stimulus stream
// and are checked against a queue-based handshake model and a pattern-table decoder.
module tb_id_queue_stage;

  localparam int Depth = 4;
  localparam int ImN = 0, ImI = 1, ImS = 2, ImB = 3, ImU = 4, ImJ = 5;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int ep, alu, br, st, ld, imm, xl;
    bit m_op;
  } pat_t;

  typedef struct packed {
    logic [10:0] ep;
    logic [17:0] alu;
    logic [5:0]  br;
    logic [3:0]  st;
    logic [6:0]  ld;
    logic [3:0]  flags;  // {need_dst, sel_reg, word, illegal}
    logic [63:0] imm;
  } ref_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst, flush, f_valid, e_ready;
  logic [31:0] f_instr;
  logic [63:0] f_pc;

  logic        rdy64, vld64, need64, sel64, word64, ill64;
  logic [63:0] pc64, imm64;
  logic [4:0]  rs1_64, rs2_64, dst64;
  logic [10:0] ep64;
  logic [17:0] alu64;
  logic [5:0]  br64;
  logic [3:0]  st64;
  logic [6:0]  ld64;

  logic        rdy32, vld32, need32, sel32, word32, ill32;
  logic [31:0] pc32, imm32;
  logic [4:0]  rs1_32, rs2_32, dst32;
  logic [10:0] ep32;
  logic [17:0] alu32;
  logic [5:0]  br32;
  logic [3:0]  st32;
  logic [6:0]  ld32;

  int   checks = 0;
  int   failures = 0;
  pat_t pats[$];
  ent_t q[$];
  ent_t exp_ent;
  bit   exp_valid = 1'b0;
  bit   exp_zero = 1'b1;
  logic [63:0] pc_ctr = 64'h1000;

  always #5 clk = ~clk;

  id_queue_stage #(.XLEN(64), .DEPTH(Depth), .EN_M(1'b1)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .F_valid_i(f_valid), .F_ready_o(rdy64),
    .F_instr_i(f_instr), .F_pc_i(f_pc), .E_ready_i(e_ready), .D_valid_o(vld64),
    .D_pc_o(pc64), .D_rs1_o(rs1_64), .D_rs2_o(rs2_64), .D_dstE_o(dst64),
    .D_need_dstE_o(need64), .D_epcode_o(ep64), .D_ALU_op_o(alu64), .D_branch_op_o(br64),
    .D_store_op_o(st64), .D_load_op_o(ld64), .D_imme_o(imm64), .D_sel_reg_o(sel64),
    .D_word_o(word64), .D_illegal_o(ill64)
  );

  id_queue_stage #(.XLEN(32), .DEPTH(Depth), .EN_M(1'b0)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .F_valid_i(f_valid), .F_ready_o(rdy32),
    .F_instr_i(f_instr), .F_pc_i(f_pc[31:0]), .E_ready_i(e_ready), .D_valid_o(vld32),
    .D_pc_o(pc32), .D_rs1_o(rs1_32), .D_rs2_o(rs2_32), .D_dstE_o(dst32),
    .D_need_dstE_o(need32), .D_epcode_o(ep32), .D_ALU_op_o(alu32), .D_branch_op_o(br32),
    .D_store_op_o(st32), .D_load_op_o(ld32), .D_imme_o(imm32), .D_sel_reg_o(sel32),
    .D_word_o(word32), .D_illegal_o(ill32)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7);
    return {f7, 10'b0, f3, 5'b0, op};
  endfunction

  function automatic void add_pat(input logic [31:0] mask, input logic [31:0] match,
                                  input int ep, input int alu, input int br, input int st,
                                  input int ld, input int imm, input int xl, input bit m);
    pat_t p;
    p.mask = mask; p.match = match; p.ep = ep; p.alu = alu; p.br = br; p.st = st;
    p.ld = ld; p.imm = imm; p.xl = xl; p.m_op = m;
    pats.push_back(p);
  endfunction

  // Legal encodings as mask/match rows, straight from the instruction listing.
  function automatic void build_pats();
    int br_f3[6]   = '{0, 1, 4, 5, 6, 7};
    int alu_r0[8]  = '{0, 2, 3, 4, 5, 6, 8, 9};
    int alu_m[8]   = '{10, 11, 13, 12, 14, 15, 16, 17};
    int ai_f3[6]   = '{0, 2, 3, 4, 6, 7};
    int ai_alu[6]  = '{0, 3, 4, 5, 8, 9};
    logic [31:0] mop = 32'h0000007f, mf3 = 32'h0000707f;
    logic [31:0] mf7 = 32'hfe00707f, mf6 = 32'hfc00707f;
    for (int k = 0; k < 6; k++)
      add_pat(mf3, enc(7'h63, 3'(br_f3[k]), 7'h0), 0, -1, k, -1, -1, ImB, 0, 0);
    add_pat(mop, enc(7'h6f, 3'd0, 7'h0), 1, -1, -1, -1, -1, ImJ, 0, 0);
    add_pat(mf3, enc(7'h67, 3'd0, 7'h0), 2, -1, -1, -1, -1, ImI, 0, 0);
    for (int k = 0; k < 4; k++)
      add_pat(mf3, enc(7'h23, 3'(k), 7'h0), 3, -1, -1, k, -1, ImS, (k == 3) ? 64 : 0, 0);
    for (int k = 0; k < 7; k++)
      add_pat(mf3, enc(7'h03, 3'(k), 7'h0), 4, -1, -1, -1, k, ImI,
              (k == 3 || k == 6) ? 64 : 0, 0);
    for (int k = 0; k < 8; k++) begin
      add_pat(mf7, enc(7'h33, 3'(k), 7'h00), 5, alu_r0[k], -1, -1, -1, ImN, 0, 0);
      add_pat(mf7, enc(7'h33, 3'(k), 7'h01), 5, alu_m[k], -1, -1, -1, ImN, 0, 1);
    end
    add_pat(mf7, enc(7'h33, 3'd0, 7'h20), 5, 1, -1, -1, -1, ImN, 0, 0);
    add_pat(mf7, enc(7'h33, 3'd5, 7'h20), 5, 7, -1, -1, -1, ImN, 0, 0);
    add_pat(mf7, enc(7'h3b, 3'd0, 7'h00), 6, 0, -1, -1, -1, ImN, 64, 0);
    add_pat(mf7, enc(7'h3b, 3'd1, 7'h00), 6, 2, -1, -1, -1, ImN, 64, 0);
    add_pat(mf7, enc(7'h3b, 3'd5, 7'h00), 6, 6, -1, -1, -1, ImN, 64, 0);
    add_pat(mf7, enc(7'h3b, 3'd0, 7'h20), 6, 1, -1, -1, -1, ImN, 64, 0);
    add_pat(mf7, enc(7'h3b, 3'd5, 7'h20), 6, 7, -1, -1, -1, ImN, 64, 0);
    for (int k = 0; k < 6; k++)
      add_pat(mf3, enc(7'h13, 3'(ai_f3[k]), 7'h0), 7, ai_alu[k], -1, -1, -1, ImI, 0, 0);
    add_pat(mf6, enc(7'h13, 3'd1, 7'h00), 7, 2, -1, -1, -1, ImI, 64, 0);
    add_pat(mf6, enc(7'h13, 3'd5, 7'h00), 7, 6, -1, -1, -1, ImI, 64, 0);
    add_pat(mf6, enc(7'h13, 3'd5, 7'h20), 7, 7, -1, -1, -1, ImI, 64, 0);
    add_pat(mf7, enc(7'h13, 3'd1, 7'h00), 7, 2, -1, -1, -1, ImI, 32, 0);
    add_pat(mf7, enc(7'h13, 3'd5, 7'h00), 7, 6, -1, -1, -1, ImI, 32, 0);
    add_pat(mf7, enc(7'h13, 3'd5, 7'h20), 7, 7, -1, -1, -1, ImI, 32, 0);
    add_pat(mf3, enc(7'h1b, 3'd0, 7'h00), 8, 0, -1, -1, -1, ImI, 64, 0);
    add_pat(mf7, enc(7'h1b, 3'd1, 7'h00), 8, 2, -1, -1, -1, ImI, 64, 0);
    add_pat(mf7, enc(7'h1b, 3'd5, 7'h00), 8, 6, -1, -1, -1, ImI, 64, 0);
    add_pat(mf7, enc(7'h1b, 3'd5, 7'h20), 8, 7, -1, -1, -1, ImI, 64, 0);
    add_pat(mop, enc(7'h37, 3'd0, 7'h0), 9, -1, -1, -1, -1, ImU, 0, 0);
    add_pat(mop, enc(7'h17, 3'd0, 7'h0), 10, -1, -1, -1, -1, ImU, 0, 0);
  endfunction

  function automatic ref_t ref_decode(input logic [31:0] ins, input int xlen, input bit enm);
    ref_t r;
    pat_t p;
    int hit;
    logic signed [11:0] ti, ts;
    logic signed [12:0] tb;
    logic signed [20:0] tj;
    logic signed [31:0] tu;
    longint v;
    r = '0;
    hit = -1;
    for (int k = 0; k < pats.size(); k++)
      if (hit < 0 && (ins & pats[k].mask) == pats[k].match &&
          (pats[k].xl == 0 || pats[k].xl == xlen) && (!pats[k].m_op || enm))
        hit = k;
    if (hit < 0) begin
      r.flags = 4'b0101;
      return r;
    end
    p = pats[hit];
    r.ep[p.ep] = 1'b1;
    if (p.alu >= 0) r.alu[p.alu] = 1'b1;
    if (p.br >= 0)  r.br[p.br] = 1'b1;
    if (p.st >= 0)  r.st[p.st] = 1'b1;
    if (p.ld >= 0)  r.ld[p.ld] = 1'b1;
    ti = ins[31:20];
    ts = {ins[31:25], ins[11:7]};
    tb = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    tj = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    tu = {ins[31:12], 12'b0};
    case (p.imm)
      ImI:     v = longint'(ti);
      ImS:     v = longint'(ts);
      ImB:     v = longint'(tb);
      ImU:     v = longint'(tu);
      ImJ:     v = longint'(tj);
      default: v = 0;
    endcase
    r.imm = (xlen == 32) ? {32'b0, v[31:0]} : v;
    r.flags = {p.ep != 0 && p.ep != 3, p.ep != 4, p.ep == 6 || p.ep == 8, 1'b0};
    return r;
  endfunction

  task automatic cmp_dut(input string tag, input int xlen, input bit enm, input logic rdy,
                         input logic vld, input logic [63:0] pc, input logic [14:0] regs,
                         input logic [10:0] ep, input logic [17:0] alu, input logic [16:0] bsl,
                         input logic [63:0] imm, input logic [3:0] flags);
    ref_t r;
    check_val({tag, ".ready"}, rdy, q.size() != Depth);
    check_val({tag, ".valid"}, vld, exp_valid);
    if (exp_valid) begin
      r = ref_decode(exp_ent.instr, xlen, enm);
      check_val({tag, ".pc"}, pc, (xlen == 32) ? {32'b0, exp_ent.pc[31:0]} : exp_ent.pc);
      check_val({tag, ".regs"}, regs,
                {exp_ent.instr[19:15], exp_ent.instr[24:20], exp_ent.instr[11:7]});
      check_val({tag, ".epcode"}, ep, r.ep);
      check_val({tag, ".alu"}, alu, r.alu);
      check_val({tag, ".br_st_ld"}, bsl, {r.br, r.st, r.ld});
      check_val({tag, ".imm"}, imm, r.imm);
      check_val({tag, ".flags"}, flags, r.flags);
    end else if (exp_zero) begin
      check_val({tag, ".rst_fields"}, {pc ^ imm, 49'b0, regs}, 64'b0);
      check_val({tag, ".rst_ctrl"}, {ep, alu, bsl, flags}, 64'b0);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                      input bit er, input bit fl, input bit rs);
    bit do_push, do_pop;
    ent_t e;
    f_valid = v; f_instr = ins; f_pc = pc; e_ready = er; flush = fl; rst = rs;
    @(posedge clk);
    e.pc = pc;
    e.instr = ins;
    if (rs) begin
      q.delete(); exp_valid = 1'b0; exp_zero = 1'b1;
    end else if (fl) begin
      q.delete(); exp_valid = 1'b0;
    end else begin
      do_push = v && (q.size() != Depth);
      do_pop  = (q.size() != 0) && (!exp_valid || er);
      if (do_pop) begin
        exp_ent = q.pop_front(); exp_valid = 1'b1; exp_zero = 1'b0;
      end else if (er) begin
        exp_valid = 1'b0;
      end
      if (do_push) q.push_back(e);
    end
    #1;
    cmp_dut("d64", 64, 1'b1, rdy64, vld64, pc64, {rs1_64, rs2_64, dst64}, ep64, alu64,
            {br64, st64, ld64}, imm64, {need64, sel64, word64, ill64});
    cmp_dut("d32", 32, 1'b0, rdy32, vld32, {32'b0, pc32}, {rs1_32, rs2_32, dst32}, ep32,
            alu32, {br32, st32, ld32}, {32'b0, imm32}, {need32, sel32, word32, ill32});
  endtask

  // Push one instruction into an idle pipe and let it reach the output register.
  task automatic show(input logic [31:0] ins);
    step(1'b1, ins, pc_ctr, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    pc_ctr += 4;
  endtask

  function automatic logic [31:0] rand_instr();
    pat_t p;
    if ($urandom_range(0, 7) == 0) return $urandom();
    p = pats[$urandom_range(0, pats.size() - 1)];
    return ($urandom() & ~p.mask) | p.match;
  endfunction

  initial begin
    build_pats();
    step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h00500093, 64'h40, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    check_val("rst_sel_reg", sel64, 1'b0);

    show(32'h00500093);
    check_val("addi_valid", vld64, 1'b1);
    check_val("addi_ep", ep64, 64'h080);
    check_val("addi_alu", alu64, 64'h00001);
    check_val("addi_regs", {rs1_64, dst64}, {5'd0, 5'd1});
    check_val("addi_imm", imm64, 64'd5);
    check_val("addi_need_ill", {need64, ill64}, 2'b10);
    show(32'h12345137);
    check_val("lui_imm", imm64, 64'h0000000012345000);
    show(32'h800000b7);
    check_val("lui_neg_imm", imm64, 64'hFFFFFFFF80000000);
    check_val("lui_neg_imm32", imm32, 64'h80000000);
    show(32'h022081B3);
    check_val("mul_alu", alu64, 64'h00400);
    check_val("mul_ep", ep64, 64'h020);
    check_val("mul_nom_ill", {ill32, ep32, alu32}, {1'b1, 29'b0});
    show(32'h0010009B);
    check_val("addiw_rv32_ill", ill32, 1'b1);
    check_val("addiw_rv64_ep", {ill64, ep64}, {1'b0, 11'h100});
    show(32'h00000000);
    check_val("zero_ill", {ill64, ill32}, 2'b11);

    // Backpressure: first instr parks in the output register, four more fill the FIFO.
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b1, rand_instr(), 64'h2000 + 64'(i * 4), 1'b0, 1'b0, 1'b0);
    check_val("full_ready", {rdy64, rdy32}, 2'b00);
    step(1'b1, 32'h00500093, 64'h3000, 1'b0, 1'b0, 1'b0);
    check_val("held_pc", pc64, 64'h2000);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++)
      step(1'b1, rand_instr(), 64'h4000 + 64'(i * 4), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00500093, 64'h5000, 1'b0, 1'b1, 1'b0);
    check_val("flush_valid_ready", {vld64, rdy64}, 2'b01);
    step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    check_val("flush_dropped", vld64, 1'b0);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), {$urandom(), $urandom() & 32'hfffffffc},
           $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 499) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
